// File: rtl/snn_ctrl_pkg.sv
// Shared encodings for the SNN inference controller: FSM states, register map,
// CTRL/STATUS bit positions and AXI response codes.
package snn_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  // Word indices (byte address >> 2)
  localparam int unsigned REG_CTRL   = 0;
  localparam int unsigned REG_STATUS = 1;
  localparam int unsigned REG_RESULT = 2;

  localparam int unsigned CTRL_START    = 0;
  localparam int unsigned CTRL_FIFO_CLR = 1;
  localparam int unsigned CTRL_IRQ_EN   = 2;

  localparam int unsigned STAT_BUSY      = 0;
  localparam int unsigned STAT_EMPTY     = 1;
  localparam int unsigned STAT_FULL      = 2;
  localparam int unsigned STAT_OVERFLOW  = 3;
  localparam int unsigned STAT_TIMEOUT   = 4;
  localparam int unsigned STAT_COUNT_LSB = 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/snn_result_fifo.sv
// Small result FIFO for inferred digits; clear has priority over push and pop,
// and a push into a full FIFO is accepted only when a pop happens the same cycle.
module snn_result_fifo
  import snn_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       ACLK,
  input  logic                       ARESETN,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clr,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop && !empty && !clr;
  assign do_push = push && !clr && (!full || do_pop);

  always_ff @(posedge ACLK) begin
    if (!ARESETN || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset; validity is tracked by count
  always_ff @(posedge ACLK) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/snn_inference_ctrl.sv
// AXI-Lite controller that launches SNN inferences and queues their results.
// Optional watchdog on the RUN state is enabled with `define SNN_CTRL_TIMEOUT_EN.
module snn_inference_ctrl
  import snn_ctrl_pkg::*;
#(
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ADDR_WIDTH = 7,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic                        ACLK,
  input  logic                        ARESETN,
  input  logic [31:0]                 AWADDR,
  input  logic                        AWVALID,
  output logic                        AWREADY,
  input  logic [AXI_DATA_WIDTH-1:0]   WDATA,
  input  logic [AXI_DATA_WIDTH/8-1:0] WSTRB,
  input  logic                        WVALID,
  output logic                        WREADY,
  output logic [1:0]                  BRESP,
  output logic                        BVALID,
  input  logic                        BREADY,
  input  logic [31:0]                 ARADDR,
  input  logic [2:0]                  ARPROT,
  input  logic                        ARVALID,
  output logic                        ARREADY,
  output logic [AXI_DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]                  RRESP,
  output logic                        RVALID,
  input  logic                        RREADY,
  output logic                        SNN_START,
  input  logic                        COPROCESSOR_RDY,
  input  logic [7:0]                  INFERED_DIGIT,
  output logic                        IRQ
);

  localparam int unsigned IDXW = AXI_ADDR_WIDTH - 2;
  localparam int unsigned CNTW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]      state_q, state_d;
  logic            rdy_q;
  logic            irq_en_q, overflow_q, timeout_q;
  logic            wr_hs, ar_hs, ctrl_wr, start_req, rdy_rise;
  logic [IDXW-1:0] wr_idx, rd_idx;
  logic            fifo_push, fifo_pop, fifo_clr, fifo_full, fifo_empty;
  logic [7:0]      fifo_dout;
  logic [CNTW-1:0] fifo_count;
  logic            timeout_hit;
  logic [31:0]     status_word;
  logic [AXI_DATA_WIDTH-1:0] rd_data;
  logic [1:0]      rd_resp;

  assign wr_idx    = AWADDR[AXI_ADDR_WIDTH-1:2];
  assign rd_idx    = ARADDR[AXI_ADDR_WIDTH-1:2];
  assign wr_hs     = AWVALID && WVALID && !BVALID;
  assign AWREADY   = wr_hs;
  assign WREADY    = wr_hs;
  assign ARREADY   = !RVALID;
  assign ar_hs     = ARVALID && !RVALID;
  assign ctrl_wr   = wr_hs && (wr_idx == IDXW'(REG_CTRL)) && WSTRB[0];
  assign start_req = ctrl_wr && WDATA[CTRL_START];
  assign fifo_clr  = ctrl_wr && WDATA[CTRL_FIFO_CLR];
  assign fifo_pop  = ar_hs && (rd_idx == IDXW'(REG_RESULT)) && !fifo_empty;
  assign rdy_rise  = COPROCESSOR_RDY && !rdy_q;

`ifdef SNN_CTRL_TIMEOUT_EN
  localparam int unsigned TCW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TCW-1:0] tmo_cnt_q;

  // Counts cycles spent in RUN; restarts on every new inference
  always_ff @(posedge ACLK) begin
    if (!ARESETN || state_q != ST_RUN) tmo_cnt_q <= '0;
    else                               tmo_cnt_q <= tmo_cnt_q + TCW'(1);
  end
`endif

  always_ff @(posedge ACLK) begin
    if (!ARESETN) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    fifo_push   = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      ST_IDLE:  if (start_req) state_d = ST_START;
      ST_START: state_d = ST_RUN;
      ST_RUN: begin
        if (rdy_rise) begin
          fifo_push = 1'b1;
          state_d   = ST_IDLE;
        end
`ifdef SNN_CTRL_TIMEOUT_EN
        else if (tmo_cnt_q == TCW'(TIMEOUT_CYCLES - 1)) begin
          timeout_hit = 1'b1;
          state_d     = ST_IDLE;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  snn_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .clr     (fifo_clr),
    .din     (INFERED_DIGIT),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign status_word = {21'b0, 3'(fifo_count), 3'b0, timeout_q, overflow_q,
                        fifo_full, fifo_empty, (state_q != ST_IDLE)};

  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    case (rd_idx)
      IDXW'(REG_STATUS): rd_data = AXI_DATA_WIDTH'(status_word);
      IDXW'(REG_RESULT): if (!fifo_empty) rd_data = AXI_DATA_WIDTH'({1'b1, 23'b0, fifo_dout});
      default:           rd_resp = RESP_SLVERR;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      rdy_q      <= 1'b0;
      irq_en_q   <= 1'b0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
      SNN_START  <= 1'b0;
      IRQ        <= 1'b0;
      BVALID     <= 1'b0;
      BRESP      <= RESP_OKAY;
      RVALID     <= 1'b0;
      RDATA      <= '0;
      RRESP      <= RESP_OKAY;
    end else begin
      rdy_q     <= COPROCESSOR_RDY;
      SNN_START <= (state_d == ST_START);
      IRQ       <= irq_en_q && !fifo_empty;
      if (ctrl_wr) irq_en_q <= WDATA[CTRL_IRQ_EN];
      // Clear beats any same-cycle overflow or timeout event
      if (fifo_clr) begin
        overflow_q <= 1'b0;
        timeout_q  <= 1'b0;
      end else begin
        if (fifo_push && fifo_full && !fifo_pop) overflow_q <= 1'b1;
        if (timeout_hit)                         timeout_q  <= 1'b1;
      end
      if (wr_hs)       BVALID <= 1'b1;
      else if (BREADY) BVALID <= 1'b0;
      BRESP <= RESP_OKAY;
      if (ar_hs) begin
        RVALID <= 1'b1;
        RDATA  <= rd_data;
        RRESP  <= rd_resp;
      end else if (RREADY) begin
        RVALID <= 1'b0;
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{WDATA[AXI_DATA_WIDTH-1:3], WSTRB[AXI_DATA_WIDTH/8-1:1],
                         AWADDR[31:AXI_ADDR_WIDTH], AWADDR[1:0],
                         ARADDR[31:AXI_ADDR_WIDTH], ARADDR[1:0], ARPROT,
                         (TIMEOUT_CYCLES == 0)};

endmodule

// File: tb/tb_snn_inference_ctrl.sv
// Directed bench for snn_inference_ctrl; read expectations go through a scoreboard queue.
// Timeout scenario is compiled in when SNN_CTRL_TIMEOUT_EN is defined.
module tb_snn_inference_ctrl;

  localparam logic [31:0] A_CTRL   = 32'h00;
  localparam logic [31:0] A_STATUS = 32'h04;
  localparam logic [31:0] A_RESULT = 32'h08;

  typedef struct packed {
    logic [1:0]  resp;
    logic [31:0] data;
  } rd_exp_t;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [31:0] AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [31:0] ARADDR;
  logic [2:0]  ARPROT;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;
  logic        SNN_START;
  logic        COPROCESSOR_RDY;
  logic [7:0]  INFERED_DIGIT;
  logic        IRQ;

  int vectors     = 0;
  int miscompares = 0;
  int pulse_cnt   = 0;
  int run_len     = 0;
  int max_len     = 0;
  rd_exp_t sb_q[$];

  always #5 ACLK = ~ACLK;

  snn_inference_ctrl #(
    .AXI_DATA_WIDTH (32),
    .AXI_ADDR_WIDTH (7),
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .ACLK            (ACLK),
    .ARESETN         (ARESETN),
    .AWADDR          (AWADDR),
    .AWVALID         (AWVALID),
    .AWREADY         (AWREADY),
    .WDATA           (WDATA),
    .WSTRB           (WSTRB),
    .WVALID          (WVALID),
    .WREADY          (WREADY),
    .BRESP           (BRESP),
    .BVALID          (BVALID),
    .BREADY          (BREADY),
    .ARADDR          (ARADDR),
    .ARPROT          (ARPROT),
    .ARVALID         (ARVALID),
    .ARREADY         (ARREADY),
    .RDATA           (RDATA),
    .RRESP           (RRESP),
    .RVALID          (RVALID),
    .RREADY          (RREADY),
    .SNN_START       (SNN_START),
    .COPROCESSOR_RDY (COPROCESSOR_RDY),
    .INFERED_DIGIT   (INFERED_DIGIT),
    .IRQ             (IRQ)
  );

  // Start pulse monitor: total pulses and longest run of high cycles
  always @(posedge ACLK) begin
    if (SNN_START === 1'b1) begin
      pulse_cnt = (run_len == 0) ? pulse_cnt + 1 : pulse_cnt;
      run_len   = run_len + 1;
      if (run_len > max_len) max_len = run_len;
    end else begin
      run_len = 0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge ACLK);
    #1;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    AWADDR  = addr;
    WDATA   = data;
    WSTRB   = strb;
    AWVALID = 1'b1;
    WVALID  = 1'b1;
    #1;
    check("awready", 32'(AWREADY), 32'd1);
    tick(1);
    AWVALID = 1'b0;
    WVALID  = 1'b0;
    #1;
    check("bvalid", 32'(BVALID), 32'd1);
    check("bresp", 32'(BRESP), 32'd0);
    BREADY = 1'b1;
    tick(1);
    BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp, input int hold);
    rd_exp_t e;
    int n;
    sb_q.push_back({exp_resp, exp_data});
    ARADDR  = addr;
    ARVALID = 1'b1;
    n = 0;
    #1;
    while (ARREADY !== 1'b1 && n < 50) begin
      tick(1);
      n++;
    end
    check("arready", 32'(ARREADY), 32'd1);
    tick(1);
    ARVALID = 1'b0;
    #1;
    check("rvalid", 32'(RVALID), 32'd1);
    for (int i = 0; i < hold; i++) begin
      tick(1);
      check("rvalid_hold", 32'(RVALID), 32'd1);
      check("rdata_hold", RDATA, sb_q[0].data);
    end
    e = sb_q.pop_front();
    check("rdata", RDATA, e.data);
    check("rresp", 32'(RRESP), 32'(e.resp));
    RREADY = 1'b1;
    tick(1);
    RREADY = 1'b0;
  endtask

  task automatic coproc_finish(input logic [7:0] digit, input int delay);
    tick(delay);
    INFERED_DIGIT   = digit;
    COPROCESSOR_RDY = 1'b1;
    tick(1);
    COPROCESSOR_RDY = 1'b0;
    tick(1);
  endtask

  task automatic infer(input logic [31:0] ctrl, input logic [7:0] digit);
    axi_write(A_CTRL, ctrl, 4'hF);
    coproc_finish(digit, 3);
  endtask

  initial begin
    int p0;
    ARESETN = 1'b0;
    AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b0;
    ARADDR = '0; ARPROT = '0; ARVALID = 1'b0; RREADY = 1'b0;
    COPROCESSOR_RDY = 1'b0; INFERED_DIGIT = '0;
    tick(3);
    check("rst_bvalid", 32'(BVALID), 32'd0);
    check("rst_rvalid", 32'(RVALID), 32'd0);
    check("rst_rdata", RDATA, 32'd0);
    check("rst_irq", 32'(IRQ), 32'd0);
    check("rst_snn_start", 32'(SNN_START), 32'd0);
    ARESETN = 1'b1;
    tick(1);
    axi_read(A_STATUS, 32'h0000_0002, 2'b00, 0);

    // Single inference
    axi_write(A_CTRL, 32'h1, 4'hF);
    axi_read(A_STATUS, 32'h0000_0003, 2'b00, 0);
    coproc_finish(8'h07, 10);
    check("start_pulses_1", 32'(pulse_cnt), 32'd1);
    axi_read(A_STATUS, 32'h0000_0100, 2'b00, 0);
    axi_read(A_RESULT, 32'h8000_0007, 2'b00, 0);
    axi_read(A_STATUS, 32'h0000_0002, 2'b00, 0);

    // Overflow: five results, four kept
    for (int d = 1; d <= 5; d++) infer(32'h1, 8'(d));
    axi_read(A_STATUS, 32'h0000_040C, 2'b00, 0);
    for (int d = 1; d <= 4; d++) axi_read(A_RESULT, 32'h8000_0000 | 32'(d), 2'b00, 0);
    axi_read(A_RESULT, 32'h0, 2'b00, 0);
    axi_read(A_STATUS, 32'h0000_000A, 2'b00, 0);
    axi_write(A_CTRL, 32'h2, 4'hF);
    axi_read(A_STATUS, 32'h0000_0002, 2'b00, 0);

    // Push and pop on the same edge while full
    for (int d = 'h11; d <= 'h14; d++) infer(32'h1, 8'(d));
    axi_write(A_CTRL, 32'h1, 4'hF);
    tick(2);
    INFERED_DIGIT   = 8'h15;
    COPROCESSOR_RDY = 1'b1;
    axi_read(A_RESULT, 32'h8000_0011, 2'b00, 0);
    COPROCESSOR_RDY = 1'b0;
    axi_read(A_STATUS, 32'h0000_0404, 2'b00, 0);
    for (int d = 'h12; d <= 'h15; d++) axi_read(A_RESULT, 32'h8000_0000 | 32'(d), 2'b00, 0);
    axi_read(A_STATUS, 32'h0000_0002, 2'b00, 0);

    // START ignored while busy; unmapped read
    p0 = pulse_cnt;
    axi_write(A_CTRL, 32'h1, 4'hF);
    axi_write(A_CTRL, 32'h1, 4'hF);
    tick(3);
    check("no_restart", 32'(pulse_cnt - p0), 32'd1);
    axi_read(32'h0C, 32'h0, 2'b10, 0);
    coproc_finish(8'h09, 2);
    axi_read(A_RESULT, 32'h8000_0009, 2'b00, 0);

    // Interrupt and R-channel backpressure
    axi_write(A_CTRL, 32'h4, 4'hF);
    tick(2);
    check("irq_empty", 32'(IRQ), 32'd0);
    infer(32'h5, 8'h42);
    check("irq_set", 32'(IRQ), 32'd1);
    axi_read(A_RESULT, 32'h8000_0042, 2'b00, 5);
    check("irq_clear", 32'(IRQ), 32'd0);

    // Writes that must have no effect
    p0 = pulse_cnt;
    axi_write(32'h10, 32'h1, 4'hF);
    axi_write(A_CTRL, 32'h1, 4'h0);
    tick(3);
    check("no_effect_writes", 32'(pulse_cnt - p0), 32'd0);
    axi_read(A_STATUS, 32'h0000_0002, 2'b00, 0);

    // Reset in RUN abandons the inference
    axi_write(A_CTRL, 32'h1, 4'hF);
    tick(2);
    ARESETN = 1'b0;
    tick(2);
    ARESETN = 1'b1;
    check("rst_run_snn_start", 32'(SNN_START), 32'd0);
    coproc_finish(8'h33, 2);
    axi_read(A_STATUS, 32'h0000_0002, 2'b00, 0);
    axi_read(A_RESULT, 32'h0, 2'b00, 0);

`ifdef SNN_CTRL_TIMEOUT_EN
    axi_write(A_CTRL, 32'h1, 4'hF);
    axi_read(A_STATUS, 32'h0000_0003, 2'b00, 0);
    tick(25);
    axi_read(A_STATUS, 32'h0000_0012, 2'b00, 0);
    axi_write(A_CTRL, 32'h2, 4'hF);
    axi_read(A_STATUS, 32'h0000_0002, 2'b00, 0);
`endif

    check("start_pulse_width", 32'(max_len), 32'd1);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
